// File: rtl/join_fork_net.sv
// Join/fork token network: each input forks to its masked outputs,
// each output fires once every masked input has delivered a token.
module join_fork_net #(
  parameter int                    N_IN      = 4,
  parameter int                    N_OUT     = 4,
  parameter logic [N_OUT*N_IN-1:0] JOIN_MASK = 16'hF731,
  parameter int                    CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  i_vld,
  output logic [N_IN-1:0]  i_rdy,
  output logic [N_OUT-1:0] o_vld,
  input  logic [N_OUT-1:0] o_rdy,
  output logic [CNT_W-1:0] fire_cnt
);

  localparam int NP = N_OUT * N_IN;

  logic [NP-1:0]    p_q, p_d;
  logic [N_OUT-1:0] o_vld_q, o_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_OUT-1:0] join_ok;
  logic [N_OUT-1:0] fire;
  logic [N_IN-1:0]  acc;
  logic [CNT_W-1:0] fire_sum;

  always_comb begin
    join_ok  = '0;
    fire     = '0;
    i_rdy    = '1;
    acc      = '0;
    p_d      = '0;
    o_vld_d  = '0;
    fire_sum = '0;

    // An empty mask row never joins, so it never fires.
    for (int j = 0; j < N_OUT; j++) begin
      join_ok[j] = |JOIN_MASK[j*N_IN +: N_IN];
      for (int k = 0; k < N_IN; k++) begin
        if (JOIN_MASK[j*N_IN+k] && !p_q[j*N_IN+k])
          join_ok[j] = 1'b0;
      end
      fire[j] = join_ok[j] & (~o_vld_q[j] | o_rdy[j]);
    end

    // A pending slot frees up in the same cycle its output fires.
    for (int k = 0; k < N_IN; k++) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (JOIN_MASK[j*N_IN+k] && p_q[j*N_IN+k] && !fire[j])
          i_rdy[k] = 1'b0;
      end
    end

    acc = i_vld & i_rdy;

    for (int j = 0; j < N_OUT; j++) begin
      for (int k = 0; k < N_IN; k++) begin
        p_d[j*N_IN+k] = JOIN_MASK[j*N_IN+k]
                      & ((p_q[j*N_IN+k] & ~fire[j]) | acc[k]);
      end
      o_vld_d[j] = fire[j] | (o_vld_q[j] & ~o_rdy[j]);
      fire_sum   = fire_sum + CNT_W'(fire[j]);
    end

    cnt_d = cnt_q + fire_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      o_vld_q <= '0;
      cnt_q   <= '0;
    end else begin
      p_q     <= p_d;
      o_vld_q <= o_vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_vld    = o_vld_q;
  assign fire_cnt = cnt_q;

endmodule

// File: tb/tb_join_fork_net.sv
// Scoreboard bench for join_fork_net: stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_join_fork_net;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_vld = 4'h0;
  logic [3:0] i_rdy;
  logic [3:0] o_vld;
  logic [3:0] o_rdy = 4'hF;
  logic [7:0] fire_cnt;

  logic [3:0] i_vld2 = 4'h0;
  logic [3:0] i_rdy2;
  logic [3:0] o_vld2;
  logic [3:0] o_rdy2 = 4'hF;
  logic [7:0] fire_cnt2;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vld;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];

  join_fork_net u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .i_rdy    (i_rdy),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy),
    .fire_cnt (fire_cnt)
  );

  // Output 0 joins only on input 0; other rows/columns are empty.
  join_fork_net #(.JOIN_MASK(16'h0001)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld2),
    .i_rdy    (i_rdy2),
    .o_vld    (o_vld2),
    .o_rdy    (o_rdy2),
    .fire_cnt (fire_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      n_run++;
      if (o_vld !== e.vld || fire_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL sb cyc=%0d o_vld=%b fire_cnt=%0d exp %b/%0d",
                 cyc, o_vld, fire_cnt, e.vld, e.cnt);
      end
    end else if (!rst && o_vld !== 4'h0) begin
      n_run++;
      n_fail++;
      $display("FAIL spurious cyc=%0d o_vld=%b exp 0000", cyc, o_vld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v,
                      input logic [7:0] n);
    exp_t e;
    e.cyc = c;
    e.vld = v;
    e.cnt = n;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    i_vld  = 4'h0;
    i_vld2 = 4'h0;
    o_rdy  = 4'hF;
    o_rdy2 = 4'hF;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [7:0] n;

    do_reset();
    chk("rst_i_rdy", i_rdy, 4'hF);
    chk("rst_o_vld", o_vld, 4'h0);
    chk("rst_cnt", fire_cnt, 8'd0);

    // Single-output join: one token in flight plus one buffered.
    o_rdy2 = 4'h0;
    i_vld2 = 4'h1;
    chk("b_rdy0", i_rdy2, 4'hF);
    step();
    chk("b_rdy1", i_rdy2, 4'hF);
    chk("b_vld1", o_vld2, 4'h0);
    step();
    chk("b_vld2", o_vld2, 4'h1);
    chk("b_rdy2", i_rdy2, 4'hE);
    chk("b_cnt2", fire_cnt2, 8'd1);
    step();
    chk("b_vld3", o_vld2, 4'h1);
    chk("b_rdy3", i_rdy2, 4'hE);
    chk("b_cnt3", fire_cnt2, 8'd1);
    i_vld2 = 4'h0;
    o_rdy2 = 4'hF;
    step();
    chk("b_vld4", o_vld2, 4'h1);
    chk("b_cnt4", fire_cnt2, 8'd2);
    chk("b_rdy4", i_rdy2, 4'hF);
    step();
    chk("b_vld5", o_vld2, 4'h0);
    chk("b_cnt5", fire_cnt2, 8'd2);

    // Input 0 alone completes only output 0.
    do_reset();
    c = cyc;
    i_vld = 4'h1;
    push(c + 2, 4'h1, 8'd1);
    step();
    i_vld = 4'h0;
    step();
    step();
    chk("in0_rdy_blk", i_rdy[0], 1'b0);
    step();

    // All inputs once: all outputs fire together for one cycle.
    do_reset();
    c = cyc;
    i_vld = 4'hF;
    push(c + 2, 4'hF, 8'd4);
    step();
    i_vld = 4'h0;
    step();
    step();
    step();

    // Staggered join: output 1 waits for input 1.
    do_reset();
    c = cyc;
    i_vld = 4'h1;
    push(c + 2, 4'h1, 8'd1);
    step();
    i_vld = 4'h0;
    step();
    step();
    i_vld = 4'h2;
    chk("in1_rdy", i_rdy[1], 1'b1);
    push(c + 4, 4'h0, 8'd1);
    push(c + 5, 4'h2, 8'd2);
    step();
    i_vld = 4'h0;
    step();
    step();
    step();

    // Streaming at full rate, counter wraps 252 -> 0.
    do_reset();
    i_vld = 4'hF;
    n = 8'd0;
    for (int i = 0; i < 70; i++) begin
      n = n + 8'd4;
      push(cyc + 2, 4'hF, n);
      step();
    end
    i_vld = 4'h0;
    step();
    step();
    step();

    // Reset mid-flight drops pending tokens and outputs.
    do_reset();
    c = cyc;
    i_vld = 4'hF;
    push(c + 2, 4'hF, 8'd4);
    step();
    push(c + 3, 4'hF, 8'd8);
    step();
    i_vld = 4'h1;
    step();
    rst   = 1'b1;
    i_vld = 4'hF;
    step();
    rst   = 1'b0;
    i_vld = 4'h0;
    chk("mid_o_vld", o_vld, 4'h0);
    chk("mid_cnt", fire_cnt, 8'd0);
    chk("mid_i_rdy", i_rdy, 4'hF);
    step();
    step();
    step();
    step();
    chk("mid_cnt_late", fire_cnt, 8'd0);

    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
